// File: rtl/bandpower_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the bandpower readout scheduler.
//   tx_state_t : transmit FSM states
//   HDR_MAGIC  : top byte of every frame header word
package bandpower_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } tx_state_t;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

endpackage

// File: rtl/rise_pulse.sv
`timescale 1ns/1ps
// Registered 0->1 edge detector.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   i_level  : level input to watch
//   i_en     : qualifies the edge; an edge seen while low is discarded
//   o_pulse  : registered, one cycle high after a qualified rising edge
module rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    input  logic i_en,
    output logic o_pulse
);

    logic level_q, level_d;
    logic pulse_q, pulse_d;

    always_comb begin
        level_d = i_level;
        pulse_d = i_level & ~level_q & i_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/bandpower_readout_sched.sv
`timescale 1ns/1ps
// Bandpower readout scheduler: sits between the SPI slave and the bandpower
// engine. Turns rx-word arrivals into write strobes, buffers up to two
// completed result frames and streams them out one word per tx handshake.
//   i_sys_clk / i_sys_rst : clock, asynchronous active-high reset
//   i_enable, i_data_ready -> o_wr : gated 1-cycle sample write strobe
//   i_done, i_y           : frame-complete level and packed signed results
//   i_tx_ready, o_tx_data : tx word handshake (ready high, word taken on low)
//   o_busy                : a frame slot is occupied
//   o_overflow            : sticky, a frame was dropped with both slots full
//   o_frame_cnt           : number of captured frames, wrapping
module bandpower_readout_sched
    import bandpower_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int BAND_NUM  = 2,
    parameter int HEADER_EN = 1,
    parameter int CNT_W     = 8
) (
    input  logic                      i_sys_clk,
    input  logic                      i_sys_rst,
    input  logic                      i_enable,
    input  logic                      i_data_ready,
    output logic                      o_wr,
    input  logic                      i_done,
    input  logic [BAND_NUM*WIDTH-1:0] i_y,
    input  logic                      i_tx_ready,
    output logic [WIDTH-1:0]          o_tx_data,
    output logic                      o_busy,
    output logic                      o_overflow,
    output logic [CNT_W-1:0]          o_frame_cnt
);

    localparam int HDR_W  = (HEADER_EN != 0) ? 1 : 0;
    localparam int NWORDS = BAND_NUM + HDR_W;
    localparam int KW     = $clog2(NWORDS + 1);
    localparam int FW     = BAND_NUM * WIDTH;

    logic done_pulse;

    rise_pulse u_wr_edge (
        .clk     (i_sys_clk),
        .rst     (i_sys_rst),
        .i_level (i_data_ready),
        .i_en    (i_enable),
        .o_pulse (o_wr)
    );

    rise_pulse u_done_edge (
        .clk     (i_sys_clk),
        .rst     (i_sys_rst),
        .i_level (i_done),
        .i_en    (1'b1),
        .o_pulse (done_pulse)
    );

    // Frame slots: 2-entry FIFO of result frames plus the header count
    // latched at capture time.
    logic [FW-1:0]    slot_q [2];
    logic [FW-1:0]    slot_d [2];
    logic [CNT_W-1:0] hcnt_q [2];
    logic [CNT_W-1:0] hcnt_d [2];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;

    tx_state_t        state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic             pop;
    logic             push;
    logic [WIDTH-1:0] word_sel;
    logic [KW-1:0]    band_idx;

    // Word k of the frame at the read pointer.
    always_comb begin
        word_sel = '0;
        band_idx = k_q - KW'(HDR_W);
        if (HDR_W != 0 && k_q == '0) begin
            word_sel[WIDTH-1 -: 8]  = HDR_MAGIC;
            word_sel[CNT_W-1:0]     = hcnt_q[rptr_q];
        end else begin
            word_sel = slot_q[rptr_q][int'(band_idx)*WIDTH +: WIDTH];
        end
    end

    // Transmit FSM: a word is registered when the SPI side is ready and
    // counted as consumed when ready drops again.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = '0;
                if (occ_q != 2'd0) begin
                    k_d     = '0;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (i_tx_ready) begin
                    tx_d    = word_sel;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!i_tx_ready) begin
                    if (k_q == KW'(NWORDS - 1)) begin
                        pop     = 1'b1;
                        tx_d    = '0;
                        state_d = IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = PRESENT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture path. A pop in the same cycle frees a slot before the
    // full check, so capture-on-release never overflows.
    always_comb begin
        slot_d      = slot_q;
        hcnt_d      = hcnt_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        occ_d       = occ_q;
        frame_cnt_d = frame_cnt_q;
        ovf_d       = ovf_q;
        push        = done_pulse && ((occ_q != 2'd2) || pop);

        if (done_pulse && !push)
            ovf_d = 1'b1;

        if (push) begin
            frame_cnt_d    = frame_cnt_q + 1'b1;
            slot_d[wptr_q] = i_y;
            hcnt_d[wptr_q] = frame_cnt_d;
            wptr_d         = ~wptr_q;
        end
        if (pop)
            rptr_d = ~rptr_q;

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        busy_d = (occ_d != 2'd0);
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            slot_q[0]   <= '0;
            slot_q[1]   <= '0;
            hcnt_q[0]   <= '0;
            hcnt_q[1]   <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            occ_q       <= 2'd0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
            k_q         <= '0;
            tx_q        <= '0;
        end else begin
            slot_q      <= slot_d;
            hcnt_q      <= hcnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            occ_q       <= occ_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            state_q     <= state_d;
            k_q         <= k_d;
            tx_q        <= tx_d;
        end
    end

    assign o_tx_data   = tx_q;
    assign o_busy      = busy_q;
    assign o_overflow  = ovf_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_bandpower_readout_sched.sv
`timescale 1ns/1ps
module tb_bandpower_readout_sched;

    localparam int WIDTH    = 16;
    localparam int BAND_NUM = 2;
    localparam int CNT_W    = 8;
    localparam int NW       = BAND_NUM + 1;

    logic                      clk = 1'b0;
    logic                      i_sys_rst = 1'b1;
    logic                      i_enable = 1'b0;
    logic                      i_data_ready = 1'b0;
    logic                      o_wr;
    logic                      i_done = 1'b0;
    logic [BAND_NUM*WIDTH-1:0] i_y = '0;
    logic                      i_tx_ready = 1'b0;
    logic [WIDTH-1:0]          o_tx_data;
    logic                      o_busy;
    logic                      o_overflow;
    logic [CNT_W-1:0]          o_frame_cnt;

    always #5 clk = ~clk;

    bandpower_readout_sched #(
        .WIDTH(WIDTH), .BAND_NUM(BAND_NUM), .HEADER_EN(1), .CNT_W(CNT_W)
    ) dut (
        .i_sys_clk    (clk),
        .i_sys_rst    (i_sys_rst),
        .i_enable     (i_enable),
        .i_data_ready (i_data_ready),
        .o_wr         (o_wr),
        .i_done       (i_done),
        .i_y          (i_y),
        .i_tx_ready   (i_tx_ready),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_overflow   (o_overflow),
        .o_frame_cnt  (o_frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of expected tx words plus frame bookkeeping.
    logic [WIDTH-1:0] exp_q[$];
    int  model_occ  = 0;
    int  model_cnt  = 0;
    int  words_done = 0;
    bit  model_ovf  = 0;
    bit  mon_en     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: the word on o_tx_data is consumed when tx_ready falls.
    always @(negedge i_tx_ready) begin
        if (mon_en && !i_sys_rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_word unexpected actual=%0h expected=none", o_tx_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                chk("tx_word", o_tx_data, e);
            end
        end
    end

    // A frame arriving: queued if a slot is free, otherwise dropped.
    task automatic frame_in(input logic [31:0] y);
        if (model_occ < 2) begin
            logic [7:0] c;
            model_cnt = (model_cnt + 1) % 256;
            c = model_cnt[7:0];
            exp_q.push_back({8'hA5, c});
            exp_q.push_back(y[15:0]);
            exp_q.push_back(y[31:16]);
            model_occ++;
        end else begin
            model_ovf = 1;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_occ  = 0;
        model_cnt  = 0;
        words_done = 0;
        model_ovf  = 0;
    endtask

    task automatic do_reset();
        i_sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        i_sys_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_done(input logic [31:0] y);
        i_y    = y;
        i_done = 1'b1;
        frame_in(y);
        repeat (3) @(negedge clk);
        i_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic hs();
        i_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        i_tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        words_done++;
        if (words_done % NW == 0) begin
            model_occ--;
            chk("idle_tx_zero", o_tx_data, 0);
            chk("busy_after_frame", o_busy, (model_occ != 0));
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (model_occ > 0 && guard < 20) begin
            hs();
            guard++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        logic [31:0] y;

        repeat (3) @(negedge clk);
        chk("rst_wr", o_wr, 0);
        chk("rst_tx", o_tx_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_cnt", o_frame_cnt, 0);
        i_sys_rst = 1'b0;
        @(negedge clk);
        mon_en = 1;

        // Write gating: three enabled rises, one suppressed.
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            bit e;
            e = (i < 3);
            i_enable     = e;
            i_data_ready = 1'b1;
            for (int j = 0; j < 6; j++) begin
                @(negedge clk);
                chk("wr_pulse", o_wr, (j == 0) && e);
                if (o_wr) pulses++;
                if (j == 4) i_data_ready = 1'b0;
            end
            repeat (2) @(negedge clk);
        end
        chk("wr_count", pulses, 3);
        i_enable = 1'b1;

        // Directed frame.
        send_done({16'h0123, 16'hFFF0});
        chk("cnt_one", o_frame_cnt, 1);
        chk("busy_one", o_busy, 1);
        repeat (3) hs();
        chk("queue_empty", exp_q.size(), 0);

        // Overflow: third frame dropped, first two transmitted in order.
        do_reset();
        send_done(32'h1111_2222);
        send_done(32'h3333_4444);
        send_done(32'h5555_6666);
        chk("ovf_set", o_overflow, model_ovf);
        chk("ovf_cnt", o_frame_cnt, 2);
        drain();
        chk("ovf_sticky", o_overflow, 1);
        chk("ovf_queue_empty", exp_q.size(), 0);

        // Capture in the same cycle as the final pop with both slots full.
        do_reset();
        send_done(32'hAAAA_0001);
        send_done(32'hBBBB_0002);
        hs();
        hs();
        i_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        i_y    = 32'hCCCC_0003;
        i_done = 1'b1;
        @(negedge clk);
        i_tx_ready = 1'b0;
        words_done++;
        model_occ--;
        frame_in(32'hCCCC_0003);
        repeat (3) @(negedge clk);
        i_done = 1'b0;
        chk("simul_no_ovf", o_overflow, 0);
        chk("simul_cnt", o_frame_cnt, 3);
        chk("simul_busy", o_busy, 1);
        drain();
        chk("simul_queue_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of HOLD.
        do_reset();
        send_done(32'h7777_8888);
        i_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 i_sys_rst = 1'b1;
        #1;
        chk("arst_tx", o_tx_data, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_cnt", o_frame_cnt, 0);
        i_tx_ready = 1'b0;
        @(negedge clk);
        model_reset();
        i_sys_rst = 1'b0;
        @(negedge clk);
        send_done(32'h9999_AAAA);
        drain();
        chk("arst_queue_empty", exp_q.size(), 0);

        // Random mix of captures and handshakes, including mid-readout arrivals.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 2);
            i_enable = 1'($urandom_range(0, 1));
            if (r == 0 && model_occ < 2) begin
                y = $urandom;
                send_done(y);
            end else if (model_occ > 0) begin
                hs();
            end else begin
                @(negedge clk);
            end
        end
        drain();
        chk("rand_no_ovf", o_overflow, 0);
        chk("rand_cnt", o_frame_cnt, model_cnt);
        chk("rand_queue_empty", exp_q.size(), 0);

        // Counter wrap over 256 frames.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            y = $urandom;
            send_done(y);
            repeat (3) hs();
        end
        chk("wrap_cnt", o_frame_cnt, 0);
        chk("wrap_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
